// File: rtl/ram_bist_pkg.sv
// Shared constants for the RAM BIST controller: FSM state encoding and default pattern seed.
package ram_bist_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WRITE     = 3'd1;
  localparam logic [2:0] READ      = 3'd2;
  localparam logic [2:0] WRITE_INV = 3'd3;
  localparam logic [2:0] READ_INV  = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

endpackage

// File: rtl/ram_bist_if.sv
// Control, status and RAM-side signals of the BIST controller; master is the controller itself.
interface ram_bist_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic              abort;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W+1:0] err_cnt;
  logic [ADDR_W-1:0] fail_addr;
  logic              fail_inv;

  modport master (
    input  start, abort, ram_rdata,
    output ram_we, ram_addr, ram_wdata, busy, done, pass, err_cnt, fail_addr, fail_inv
  );

  modport slave (
    output start, abort, ram_rdata,
    input  ram_we, ram_addr, ram_wdata, busy, done, pass, err_cnt, fail_addr, fail_inv
  );
endinterface

// File: rtl/ram_bist_pattern.sv
// Expected-data generator: (addr ^ seed), optionally inverted; shared by write and compare paths.
module ram_bist_pattern #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_seed,
  input  logic              i_inv,
  output logic [DATA_W-1:0] o_data
);
  localparam int W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  logic [W-1:0] w_mix;

  assign w_mix  = W'(i_addr) ^ W'(i_seed);
  assign o_data = i_inv ? ~w_mix[DATA_W-1:0] : w_mix[DATA_W-1:0];
endmodule

// File: rtl/ram_bist.sv
// RAM BIST controller: write pattern, read back and compare, report results.
// Define RAM_BIST_INV_EN to add the inverted-pattern WRITE_INV/READ_INV pass.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int              ADDR_W = 8,
  parameter int              DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED = DATA_W'(DEFAULT_SEED)
) (
  input logic               clk,
  input logic               rst,
  ram_bist_if.master        bus
);

`ifdef RAM_BIST_INV_EN
  localparam logic [2:0] LAST_READ = READ_INV;
`else
  localparam logic [2:0] LAST_READ = READ;
`endif

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W+1:0] r_err_cnt;
  logic [ADDR_W-1:0] r_fail_addr;
  logic              r_fail_seen;
  logic              r_pass;

  logic              w_inv;
  logic              w_wr_phase;
  logic              w_rd_phase;
  logic              w_last;
  logic              w_clear;
  logic              w_mismatch;
  logic              w_run_end;
  logic [DATA_W-1:0] w_expected;

`ifdef RAM_BIST_INV_EN
  assign w_inv      = (r_state == WRITE_INV) || (r_state == READ_INV);
  assign w_wr_phase = (r_state == WRITE) || (r_state == WRITE_INV);
  assign w_rd_phase = (r_state == READ)  || (r_state == READ_INV);
`else
  assign w_inv      = 1'b0;
  assign w_wr_phase = (r_state == WRITE);
  assign w_rd_phase = (r_state == READ);
`endif

  ram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pattern (
    .i_addr (r_addr),
    .i_seed (SEED),
    .i_inv  (w_inv),
    .o_data (w_expected)
  );

  assign w_last     = &r_addr;
  assign w_clear    = bus.abort || (bus.start && ((r_state == IDLE) || (r_state == DONE)));
  assign w_mismatch = w_rd_phase && (bus.ram_rdata != w_expected);
  assign w_run_end  = w_last && (r_state == LAST_READ);

  // NOTE: RAM-side and status outputs decode straight from registers, so an async rst clears them at once.
  assign bus.ram_we    = w_wr_phase;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = w_wr_phase ? w_expected : '0;
  assign bus.busy      = w_wr_phase || w_rd_phase;
  assign bus.done      = (r_state == DONE);
  assign bus.pass      = r_pass;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.fail_addr = r_fail_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
    end else if (bus.abort) begin
      r_state <= IDLE;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state <= WRITE;
            r_addr  <= '0;
          end
        end
        WRITE: begin
          r_addr <= r_addr + 1'b1;
          if (w_last) r_state <= READ;
        end
        READ: begin
          r_addr <= r_addr + 1'b1;
`ifdef RAM_BIST_INV_EN
          if (w_last) r_state <= WRITE_INV;
`else
          if (w_last) r_state <= DONE;
`endif
        end
`ifdef RAM_BIST_INV_EN
        WRITE_INV: begin
          r_addr <= r_addr + 1'b1;
          if (w_last) r_state <= READ_INV;
        end
        READ_INV: begin
          r_addr <= r_addr + 1'b1;
          if (w_last) r_state <= DONE;
        end
`endif
        default: begin
          r_state <= IDLE;
          r_addr  <= '0;
        end
      endcase
    end
  end

  // Last read's compare is folded into pass on the same edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt   <= '0;
      r_fail_addr <= '0;
      r_fail_seen <= 1'b0;
      r_pass      <= 1'b0;
    end else if (w_clear) begin
      r_err_cnt   <= '0;
      r_fail_addr <= '0;
      r_fail_seen <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      if (w_mismatch) begin
        r_err_cnt <= r_err_cnt + 1'b1;
        if (!r_fail_seen) begin
          r_fail_addr <= r_addr;
          r_fail_seen <= 1'b1;
        end
      end
      if (w_run_end) r_pass <= (r_err_cnt == '0) && !w_mismatch;
    end
  end

`ifdef RAM_BIST_INV_EN
  logic r_fail_inv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_fail_inv <= 1'b0;
    else if (w_clear)                  r_fail_inv <= 1'b0;
    else if (w_mismatch && !r_fail_seen) r_fail_inv <= w_inv;
  end

  assign bus.fail_inv = r_fail_inv;
`else
  assign bus.fail_inv = 1'b0;
`endif

endmodule
